fifo_rd_prefetch: RTL

//   Read-side prefetch stage of the async FIFO, in the rclk domain downstream of the read-pointer/empty logic.
//   - Drives rinc into the read-pointer/empty logic; consumes its empty flag and the memory read data at raddr.
//   - Holds up to BUF_DEPTH words and presents them on a registered valid/ready stream.
//   - Result: consumers never see FIFO empty/rinc semantics or memory read timing.

---
 rtl/fifo_rd_prefetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch
//   Read-side prefetch stage of the async FIFO, clocked by rclk. It pulls words
//   out of the FIFO memory via rinc/empty/rdata and holds up to BUF_DEPTH of them
//   in a small circular buffer. That buffer feeds a registered valid/ready stream,
//   so consumers never deal with empty/rinc semantics or memory read timing.
//
// Ports
//   rclk     in   read-domain clock
//   rst_n    in   asynchronous active-low reset
//   empty    in   FIFO empty flag (registered in the read-pointer logic)
//   rdata    in   memory read data at the current raddr (combinational)
//   rinc     out  read increment; also the buffer write strobe
//   m_valid  out  head word valid
//   m_data   out  head word, always driven from buffer registers
//   m_ready  in   consumer accepts the head word
//   level    out  number of words buffered, 0..BUF_DEPTH
//   flush    in   synchronous buffer flush (only with FIFO_RD_FLUSH_EN)
//
// Build option
//   FIFO_RD_FLUSH_EN  adds the flush port. When it is undefined, flush is tied off.

module fifo_rd_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    localparam int LVL_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      level
`ifdef FIFO_RD_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam int              IDX_W    = $clog2(BUF_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [LVL_W-1:0]      count_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic [IDX_W-1:0]      rd_idx_q;

    logic flush_i;
    logic pop;
    logic push;

`ifdef FIFO_RD_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // A pop frees a slot on the same edge, so a full buffer can still accept a
    // word while draining. This gives the m_ready -> rinc combinational path.
    assign pop  = (count_q != '0) & m_ready;
    assign push = ~flush_i & ~empty & ((count_q < FULL_LVL) | pop);
    assign rinc = push;

    // BUF_DEPTH is a power of two, so the indices wrap naturally on overflow.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Words already pulled from the FIFO are dropped. The FIFO itself is untouched.
            count_q  <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q] <= rdata;
                wr_idx_q        <= wr_idx_q + IDX_W'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_valid = (count_q != '0);
    assign m_data  = mem_q[rd_idx_q];
    assign level   = count_q;

endmodule
